// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a valid/ready handshake, stall, flush and a one-entry skid buffer.
// A stage holding nothing presents BUBBLE_DATA, which is a NOP by default.
module pipe_stage_reg #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] BUBBLE_DATA = WIDTH'(32'h00000013)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             stall,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  // Handshake: a beat moves on a rising edge when valid and ready are both high.
  // Valid must not depend on ready. in_ready depends only on stage state and
  // stall, never on out_ready, so back-pressure cannot chain combinationally.
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  logic [1:0]       state, state_nxt;
  logic [WIDTH-1:0] main_q, main_nxt;
  logic [WIDTH-1:0] skid_q, skid_nxt;
  logic             live_q;
  logic             in_fire, out_fire;

  // live_q keeps in_ready low during reset and until the first edge after release.
  assign in_ready  = live_q & (state != TWO) & !stall;
  assign out_valid = (state != EMPTY) & !stall;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign out_data  = out_valid ? main_q : BUBBLE_DATA;
  assign occupancy = state;

  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    if (flush) begin
      state_nxt = EMPTY;
      main_nxt  = BUBBLE_DATA;
      skid_nxt  = BUBBLE_DATA;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state_nxt = ONE;
            main_nxt  = in_data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_nxt = in_data;
          end else if (in_fire) begin
            state_nxt = TWO;
            skid_nxt  = in_data;
          end else if (out_fire) begin
            state_nxt = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            state_nxt = ONE;
            main_nxt  = skid_q;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      main_q <= BUBBLE_DATA;
      skid_q <= BUBBLE_DATA;
      live_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      main_q <= main_nxt;
      skid_q <= skid_nxt;
      live_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a default 32-bit stage and a 64-bit stage with a zero
// bubble run in lockstep on shared controls, each with its own expected-output queue.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        iv = 1'b0, st = 1'b0, fl = 1'b0, orr = 1'b0;
  logic [31:0] id_a = '0;
  logic [63:0] id_b = '0;
  logic        ir_a, ov_a, ir_b, ov_b;
  logic [31:0] od_a;
  logic [63:0] od_b;
  logic [1:0]  occ_a, occ_b;

  logic [31:0] exp_q_a[$];
  logic [63:0] exp_q_b[$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_stage_reg dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir_a), .in_data(id_a),
    .stall(st), .flush(fl), .out_valid(ov_a), .out_ready(orr), .out_data(od_a),
    .occupancy(occ_a)
  );

  pipe_stage_reg #(.WIDTH(64), .BUBBLE_DATA(64'h0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir_b), .in_data(id_b),
    .stall(st), .flush(fl), .out_valid(ov_b), .out_ready(orr), .out_data(od_b),
    .occupancy(occ_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [63:0] d64);
    iv   = v;
    id_a = d;
    id_b = d64;
  endtask

  // Sample at the falling edge (inputs stable), score the beats that the next rising edge moves.
  task automatic cyc();
    @(negedge clk);
    chk("a_valid_implies_occ", ov_a && (occ_a == 2'd0), 0);
    chk("a_ready_implies_room", ir_a && (occ_a == 2'd2), 0);
    chk("b_valid_implies_occ", ov_b && (occ_b == 2'd0), 0);
    if (!ov_a) chk("a_bubble", od_a, 64'h13);
    if (!ov_b) chk("b_bubble", od_b, 64'h0);
    if (ov_a && orr) begin
      chk("a_output_expected", exp_q_a.size() != 0, 1);
      if (exp_q_a.size() != 0) chk("a_out_data", od_a, exp_q_a.pop_front());
    end
    if (ov_b && orr) begin
      chk("b_output_expected", exp_q_b.size() != 0, 1);
      if (exp_q_b.size() != 0) chk("b_out_data", od_b, exp_q_b.pop_front());
    end
    if (fl) begin
      exp_q_a.delete();
      exp_q_b.delete();
    end else begin
      if (iv && ir_a) exp_q_a.push_back(id_a);
      if (iv && ir_b) exp_q_b.push_back(id_b);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_occ(input string tag, input logic [1:0] exp);
    chk({tag, "_occ_a"}, occ_a, exp);
    chk({tag, "_occ_b"}, occ_b, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] s1 [3];
    s1 = '{32'h11, 32'h22, 32'h33};

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    chk("rst_out_valid", ov_a, 0);
    chk("rst_in_ready", ir_a, 0);
    chk_occ("rst", 2'd0);
    chk("rst_out_data_a", od_a, 64'h13);
    chk("rst_out_data_b", od_b, 64'h0);
    #9 rst_n = 1'b1;
    chk("rel_in_ready_before_edge", ir_a, 0);
    @(posedge clk);
    #1;
    chk("rel_in_ready_a", ir_a, 1);
    chk("rel_in_ready_b", ir_b, 1);

    // 1: stream back-to-back with out_ready=1
    orr = 1'b1;
    foreach (s1[i]) begin
      drive(1'b1, s1[i], {32'hDEADBEEF, s1[i]});
      cyc();
      chk("s1_out_valid", ov_a, 1);
      chk("s1_out_data_now", od_a, s1[i]);
      chk_occ("s1", 2'd1);
    end
    drive(1'b0, '0, '0);
    cyc();
    cyc();
    chk("s1_drained", exp_q_a.size(), 0);

    // 2 and 6: back-pressure fills the skid entry, then release
    orr = 1'b0;
    drive(1'b1, 32'hA1, 64'hDEADBEEF_00000001);
    cyc();
    drive(1'b1, 32'hA2, 64'hDEADBEEF_00000002);
    cyc();
    chk("s2_in_ready_full_a", ir_a, 0);
    chk("s2_in_ready_full_b", ir_b, 0);
    chk_occ("s2_full", 2'd2);
    drive(1'b1, 32'hA3, 64'hDEADBEEF_00000003);
    cyc();
    chk_occ("s2_held", 2'd2);
    orr = 1'b1;
    for (int i = 0; i < 3; i++) cyc();
    drive(1'b0, '0, '0);
    cyc();
    cyc();
    chk("s2_no_loss_a", exp_q_a.size(), 0);
    chk("s2_no_loss_b", exp_q_b.size(), 0);

    // 3: flush while full with a new beat offered
    orr = 1'b0;
    drive(1'b1, 32'hB1, 64'hB1);
    cyc();
    drive(1'b1, 32'hB2, 64'hB2);
    cyc();
    chk_occ("s3_pre", 2'd2);
    drive(1'b1, 32'hB0, 64'hB0);
    fl = 1'b1;
    cyc();
    fl = 1'b0;
    drive(1'b0, '0, '0);
    chk_occ("s3_post", 2'd0);
    chk("s3_out_valid", ov_a, 0);
    chk("s3_out_data", od_a, 64'h13);
    orr = 1'b1;
    cyc();
    cyc();
    chk("s3_still_empty", ov_a, 0);

    // 4: stall three cycles holding one entry
    drive(1'b1, 32'hC5, 64'hC5);
    cyc();
    drive(1'b0, '0, '0);
    st = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("s4_stall_out_valid", ov_a, 0);
      chk("s4_stall_in_ready", ir_a, 0);
      chk_occ("s4_stall", 2'd1);
      cyc();
    end
    st = 1'b0;
    cyc();
    chk("s4_emitted_once", exp_q_a.size(), 0);
    cyc();
    chk("s4_no_duplicate", ov_a, 0);

    // 5: asynchronous reset mid-cycle while full
    orr = 1'b0;
    drive(1'b1, 32'hD1, 64'hD1);
    cyc();
    drive(1'b1, 32'hD2, 64'hD2);
    cyc();
    chk_occ("s5_pre", 2'd2);
    drive(1'b0, '0, '0);
    #2 rst_n = 1'b0;
    #1;
    chk("s5_rst_out_valid", ov_a, 0);
    chk_occ("s5_rst", 2'd0);
    chk("s5_rst_in_ready", ir_a, 0);
    exp_q_a.delete();
    exp_q_b.delete();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("s5_rel_in_ready", ir_a, 1);
    chk("s5_rel_out_valid", ov_a, 0);

    // Random stream with random back-pressure to confirm FIFO order
    for (int i = 0; i < 40; i++) begin
      logic [31:0] r;
      r = $urandom;
      drive(1'($urandom_range(0, 1)), r, {~r, r});
      orr = 1'($urandom_range(0, 1));
      cyc();
    end
    drive(1'b0, '0, '0);
    orr = 1'b1;
    for (int i = 0; i < 3; i++) cyc();
    chk("rand_drained_a", exp_q_a.size(), 0);
    chk("rand_drained_b", exp_q_b.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
